// File: rtl/capture_cmd_decoder_if.sv
// Hub-side command bus of the capture command decoder: function code, strobe,
// argument registers in, result registers and status out.
interface capture_cmd_decoder_if;
    logic [7:0] command;
    logic       commandStrobe;
    logic [7:0] regIn0, regIn1, regIn2, regIn3, regIn4, regIn5, regIn6, regIn7;
    logic [7:0] regOut0, regOut1, regOut2, regOut3, regOut4, regOut5, regOut6, regOut7;
    logic [7:0] status;

    // Hub side drives commands and arguments.
    modport master (
        output command, commandStrobe,
        output regIn0, regIn1, regIn2, regIn3, regIn4, regIn5, regIn6, regIn7,
        input  regOut0, regOut1, regOut2, regOut3, regOut4, regOut5, regOut6, regOut7,
        input  status
    );

    // Decoder side returns results and status.
    modport slave (
        input  command, commandStrobe,
        input  regIn0, regIn1, regIn2, regIn3, regIn4, regIn5, regIn6, regIn7,
        output regOut0, regOut1, regOut2, regOut3, regOut4, regOut5, regOut6, regOut7,
        output status
    );
endinterface

// File: rtl/capture_cmd_decoder.sv
// Command front end of the logic capture block. Decodes hub function codes, holds
// buffer/trigger configuration, pulses capture-core strobes and returns read data.
// Every command ends with a two-phase ack: status[3] high until the hub sends ACK (08).
// Optional: define CAPTURE_CMD_DECODER_TIMEOUT_EN to bound the trace-data read wait
// to TIMEOUT_CLKS clocks (result 16'hDEAD and sticky error on expiry).
module capture_cmd_decoder #(
    parameter int unsigned SAMPLE_W     = 16,
    parameter int unsigned TIMEOUT_CLKS = 1024
) (
    input  logic                  clk,
    input  logic                  resetn,
    capture_cmd_decoder_if.slave  hub,
    output logic [31:0]           preTriggerCount,
    output logic [31:0]           totalSampleCount,
    output logic [15:0]           desiredPattern,
    output logic [15:0]           activeChannels,
    output logic [15:0]           dontCare,
    output logic [7:0]            edgeTriggerChannel,
    output logic                  edgeTriggerType,
    output logic                  edgeTriggerEnable,
    output logic                  patternTriggerEnable,
    output logic                  startPulse,
    output logic                  abortPulse,
    output logic                  captureResetPulse,
    input  logic                  captureRunning,
    input  logic                  captureDone,
    input  logic [31:0]           traceSize,
    input  logic [SAMPLE_W-1:0]   triggerSample,
    output logic                  bufRdReq,
    input  logic                  bufRdValid,
    input  logic [SAMPLE_W-1:0]   bufRdData
);

    localparam logic [7:0] CmdNop         = 8'h00;
    localparam logic [7:0] CmdStart       = 8'h01;
    localparam logic [7:0] CmdAbort       = 8'h02;
    localparam logic [7:0] CmdTrigCfg     = 8'h03;
    localparam logic [7:0] CmdBufCfg      = 8'h04;
    localparam logic [7:0] CmdReadData    = 8'h05;
    localparam logic [7:0] CmdReadSize    = 8'h06;
    localparam logic [7:0] CmdReadTrig    = 8'h07;
    localparam logic [7:0] CmdAck         = 8'h08;
    localparam logic [7:0] CmdReset       = 8'h09;
    localparam logic [7:0] CmdReadTrigAlt = 8'h10;

    typedef enum logic [1:0] {StIdle, StExec, StRdWait, StAckWait} state_e;

    state_e      state;
    logic [7:0]  cmdQ;
    logic [7:0]  argQ [8];
    logic [7:0]  regOutQ [8];
    logic        busyQ, runningQ, errorQ, ackQ, doneQ;

    logic [31:0] argPre, argTotal;
    logic [15:0] rdSample, trigSample16;
    logic        trigCfgBad, bufCfgBad;

`ifdef CAPTURE_CMD_DECODER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CLKS + 1);
    logic [CntW-1:0] rdCnt;
`endif

    assign hub.status  = {3'b000, doneQ, ackQ, errorQ, runningQ, busyQ};
    assign hub.regOut0 = regOutQ[0];
    assign hub.regOut1 = regOutQ[1];
    assign hub.regOut2 = regOutQ[2];
    assign hub.regOut3 = regOutQ[3];
    assign hub.regOut4 = regOutQ[4];
    assign hub.regOut5 = regOutQ[5];
    assign hub.regOut6 = regOutQ[6];
    assign hub.regOut7 = regOutQ[7];

    // Argument views of the captured command and the legality checks for config writes.
    always_comb begin
        argPre       = {argQ[7], argQ[6], argQ[5], argQ[4]};
        argTotal     = {argQ[3], argQ[2], argQ[1], argQ[0]};
        rdSample     = 16'(bufRdData);
        trigSample16 = 16'(triggerSample);
        // Only 16 channels exist; an out-of-range channel matters only with edge enabled.
        trigCfgBad   = captureRunning || (argQ[7][1] && (argQ[6] >= 8'd16));
        bufCfgBad    = captureRunning || (argPre > argTotal) || (argTotal == 32'd0);
    end

    // Command FSM with registered status, strobes, configuration and results.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state                <= StIdle;
            cmdQ                 <= 8'h00;
            busyQ                <= 1'b0;
            runningQ             <= 1'b0;
            errorQ               <= 1'b0;
            ackQ                 <= 1'b0;
            doneQ                <= 1'b0;
            startPulse           <= 1'b0;
            abortPulse           <= 1'b0;
            captureResetPulse    <= 1'b0;
            bufRdReq             <= 1'b0;
            preTriggerCount      <= 32'd0;
            totalSampleCount     <= 32'd0;
            desiredPattern       <= 16'h0000;
            activeChannels       <= 16'hFFFF;
            dontCare             <= 16'h0000;
            edgeTriggerChannel   <= 8'h00;
            edgeTriggerType      <= 1'b0;
            edgeTriggerEnable    <= 1'b0;
            patternTriggerEnable <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                argQ[i]    <= 8'h00;
                regOutQ[i] <= 8'h00;
            end
`ifdef CAPTURE_CMD_DECODER_TIMEOUT_EN
            rdCnt <= '0;
`endif
        end else begin
            startPulse        <= 1'b0;
            abortPulse        <= 1'b0;
            captureResetPulse <= 1'b0;
            bufRdReq          <= 1'b0;
            runningQ          <= captureRunning;
            doneQ             <= captureDone;

            unique case (state)
                StIdle: begin
                    // ACK with nothing outstanding is dropped without comment.
                    if (hub.commandStrobe && (hub.command != CmdAck)) begin
                        state   <= StExec;
                        busyQ   <= 1'b1;
                        cmdQ    <= hub.command;
                        argQ[0] <= hub.regIn0;
                        argQ[1] <= hub.regIn1;
                        argQ[2] <= hub.regIn2;
                        argQ[3] <= hub.regIn3;
                        argQ[4] <= hub.regIn4;
                        argQ[5] <= hub.regIn5;
                        argQ[6] <= hub.regIn6;
                        argQ[7] <= hub.regIn7;
                        // Strobes are launched here so they are high exactly during EXEC.
                        case (hub.command)
                            CmdStart: begin
                                if (captureRunning) begin
                                    errorQ <= 1'b1;
                                end else begin
                                    startPulse <= 1'b1;
                                end
                            end
                            CmdAbort:    abortPulse        <= 1'b1;
                            CmdReset:    captureResetPulse <= 1'b1;
                            CmdReadData: bufRdReq          <= 1'b1;
                            default:     ;
                        endcase
                    end
                end

                StExec: begin
                    state <= StAckWait;
                    ackQ  <= 1'b1;
                    case (cmdQ)
                        CmdNop, CmdStart, CmdAbort: ;
                        CmdTrigCfg: begin
                            if (trigCfgBad) begin
                                errorQ <= 1'b1;
                            end else begin
                                desiredPattern       <= {argQ[1], argQ[0]};
                                activeChannels       <= {argQ[3], argQ[2]};
                                dontCare             <= {argQ[5], argQ[4]};
                                edgeTriggerChannel   <= argQ[6];
                                edgeTriggerType      <= argQ[7][2];
                                edgeTriggerEnable    <= argQ[7][1];
                                patternTriggerEnable <= argQ[7][0];
                            end
                        end
                        CmdBufCfg: begin
                            if (bufCfgBad) begin
                                errorQ <= 1'b1;
                            end else begin
                                preTriggerCount  <= argPre;
                                totalSampleCount <= argTotal;
                            end
                        end
                        CmdReadData: begin
                            // The sample may already be valid in the request cycle.
                            if (bufRdValid) begin
                                regOutQ[0] <= rdSample[7:0];
                                regOutQ[1] <= rdSample[15:8];
                                for (int i = 2; i < 8; i++) regOutQ[i] <= 8'h00;
                            end else begin
                                state <= StRdWait;
                                ackQ  <= 1'b0;
`ifdef CAPTURE_CMD_DECODER_TIMEOUT_EN
                                rdCnt <= '0;
`endif
                            end
                        end
                        CmdReadSize: begin
                            regOutQ[0] <= traceSize[7:0];
                            regOutQ[1] <= traceSize[15:8];
                            regOutQ[2] <= traceSize[23:16];
                            regOutQ[3] <= traceSize[31:24];
                            for (int i = 4; i < 8; i++) regOutQ[i] <= 8'h00;
                        end
                        CmdReadTrig, CmdReadTrigAlt: begin
                            regOutQ[0] <= trigSample16[7:0];
                            regOutQ[1] <= trigSample16[15:8];
                            for (int i = 2; i < 8; i++) regOutQ[i] <= 8'h00;
                        end
                        CmdReset: begin
                            errorQ               <= 1'b0;
                            preTriggerCount      <= 32'd0;
                            totalSampleCount     <= 32'd0;
                            desiredPattern       <= 16'h0000;
                            activeChannels       <= 16'hFFFF;
                            dontCare             <= 16'h0000;
                            edgeTriggerChannel   <= 8'h00;
                            edgeTriggerType      <= 1'b0;
                            edgeTriggerEnable    <= 1'b0;
                            patternTriggerEnable <= 1'b0;
                        end
                        default: errorQ <= 1'b1;
                    endcase
                end

                StRdWait: begin
                    if (bufRdValid) begin
                        state      <= StAckWait;
                        ackQ       <= 1'b1;
                        regOutQ[0] <= rdSample[7:0];
                        regOutQ[1] <= rdSample[15:8];
                        for (int i = 2; i < 8; i++) regOutQ[i] <= 8'h00;
                    end
`ifdef CAPTURE_CMD_DECODER_TIMEOUT_EN
                    else if (rdCnt == CntW'(TIMEOUT_CLKS - 1)) begin
                        state      <= StAckWait;
                        ackQ       <= 1'b1;
                        errorQ     <= 1'b1;
                        regOutQ[0] <= 8'hAD;
                        regOutQ[1] <= 8'hDE;
                        for (int i = 2; i < 8; i++) regOutQ[i] <= 8'h00;
                    end else begin
                        rdCnt <= rdCnt + 1'b1;
                    end
`endif
                end

                StAckWait: begin
                    if (hub.commandStrobe) begin
                        if (hub.command == CmdAck) begin
                            state <= StIdle;
                            ackQ  <= 1'b0;
                            busyQ <= 1'b0;
                        end else begin
                            errorQ <= 1'b1;
                        end
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_cmd_decoder.sv
// Self-checking bench for capture_cmd_decoder: reset state, a directed vector table,
// hand-written multi-cycle sequences and randomized commands against a rule-level model.
module tb_capture_cmd_decoder;

    localparam int unsigned SampleW     = 16;
    localparam int unsigned TimeoutClks = 1024;

    logic        clk;
    logic        resetn;
    logic [31:0] preTriggerCount, totalSampleCount;
    logic [15:0] desiredPattern, activeChannels, dontCare;
    logic [7:0]  edgeTriggerChannel;
    logic        edgeTriggerType, edgeTriggerEnable, patternTriggerEnable;
    logic        startPulse, abortPulse, captureResetPulse;
    logic        captureRunning, captureDone;
    logic [31:0] traceSize;
    logic [15:0] triggerSample;
    logic        bufRdReq, bufRdValid;
    logic [15:0] bufRdData;

    capture_cmd_decoder_if hubIf ();

    capture_cmd_decoder #(
        .SAMPLE_W     (SampleW),
        .TIMEOUT_CLKS (TimeoutClks)
    ) dut (
        .clk                  (clk),
        .resetn               (resetn),
        .hub                  (hubIf),
        .preTriggerCount      (preTriggerCount),
        .totalSampleCount     (totalSampleCount),
        .desiredPattern       (desiredPattern),
        .activeChannels       (activeChannels),
        .dontCare             (dontCare),
        .edgeTriggerChannel   (edgeTriggerChannel),
        .edgeTriggerType      (edgeTriggerType),
        .edgeTriggerEnable    (edgeTriggerEnable),
        .patternTriggerEnable (patternTriggerEnable),
        .startPulse           (startPulse),
        .abortPulse           (abortPulse),
        .captureResetPulse    (captureResetPulse),
        .captureRunning       (captureRunning),
        .captureDone          (captureDone),
        .traceSize            (traceSize),
        .triggerSample        (triggerSample),
        .bufRdReq             (bufRdReq),
        .bufRdValid           (bufRdValid),
        .bufRdData            (bufRdData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] regOutAll, trigAll;
    assign regOutAll = {hubIf.regOut7, hubIf.regOut6, hubIf.regOut5, hubIf.regOut4,
                        hubIf.regOut3, hubIf.regOut2, hubIf.regOut1, hubIf.regOut0};
    assign trigAll   = {desiredPattern, activeChannels, dontCare, edgeTriggerChannel, 5'd0,
                        edgeTriggerType, edgeTriggerEnable, patternTriggerEnable};

    int nChecks = 0;
    int nFail   = 0;

    // Strobe counters, sampled away from the active edge.
    int startCnt = 0, abortCnt = 0, rstCnt = 0, reqCnt = 0;
    always @(negedge clk) begin
        if (startPulse)        startCnt <= startCnt + 1;
        if (abortPulse)        abortCnt <= abortCnt + 1;
        if (captureResetPulse) rstCnt   <= rstCnt + 1;
        if (bufRdReq)          reqCnt   <= reqCnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One-clock command strobe; entered and left on a falling edge.
    task automatic pulseStrobe(input logic [7:0] c, input logic [63:0] a);
        hubIf.command       = c;
        hubIf.commandStrobe = 1'b1;
        hubIf.regIn0 = a[7:0];   hubIf.regIn1 = a[15:8];
        hubIf.regIn2 = a[23:16]; hubIf.regIn3 = a[31:24];
        hubIf.regIn4 = a[39:32]; hubIf.regIn5 = a[47:40];
        hubIf.regIn6 = a[55:48]; hubIf.regIn7 = a[63:56];
        @(negedge clk);
        hubIf.commandStrobe = 1'b0;
        hubIf.command       = 8'h00;
    endtask

    // Full transaction: strobe, optional trace-sample response, bounded ack wait, ACK.
    task automatic runCmd(input logic [7:0] c, input logic [63:0] a, input int rdDelay,
                          input logic [15:0] rd);
        int lat;
        int expLat;
        pulseStrobe(c, a);
        lat = 1;
        if (c == 8'h05) begin
            for (int i = 0; i < rdDelay; i++) begin
                @(negedge clk);
                lat++;
            end
            bufRdData  = rd;
            bufRdValid = 1'b1;
        end
        while (!hubIf.status[3] && lat < 3000) begin
            @(negedge clk);
            lat++;
            bufRdValid = 1'b0;
        end
        bufRdValid = 1'b0;
        expLat = (c == 8'h05) ? 2 + rdDelay : 2;
        chk($sformatf("ackLatency_cmd%0h", c), 64'(lat), 64'(expLat));
        pulseStrobe(8'h08, 64'd0);
        chk("ackDrop", 64'({hubIf.status[3], hubIf.status[0]}), 64'd0);
    endtask

    // Rule-level reference model of configuration, error and result registers.
    logic [31:0] mPre, mTot;
    logic [15:0] mPat, mAct, mDc;
    logic [7:0]  mChan;
    logic [2:0]  mMode;
    logic        mErr;
    logic [63:0] mOut;
    int          mStart, mAbort, mRst, mReq;

    task automatic modelCfgClear();
        mPre = 0; mTot = 0; mPat = 0; mAct = 16'hFFFF; mDc = 0; mChan = 0; mMode = 0;
    endtask

    task automatic modelReset();
        modelCfgClear();
        mErr = 1'b0;
        mOut = 64'd0;
    endtask

    task automatic modelCmd(input logic [7:0] c, input logic [63:0] a, input logic run,
                            input logic [31:0] ts, input logic [15:0] tg, input logic [15:0] rd);
        mStart = 0; mAbort = 0; mRst = 0; mReq = 0;
        case (c)
            8'h00: ;
            8'h01: if (run) mErr = 1'b1; else mStart = 1;
            8'h02: mAbort = 1;
            8'h03: begin
                if (run || (a[57] && a[55:48] >= 8'd16)) mErr = 1'b1;
                else begin
                    mPat = a[15:0]; mAct = a[31:16]; mDc = a[47:32];
                    mChan = a[55:48]; mMode = a[58:56];
                end
            end
            8'h04: begin
                if (run || a[63:32] > a[31:0] || a[31:0] == 32'd0) mErr = 1'b1;
                else begin
                    mPre = a[63:32]; mTot = a[31:0];
                end
            end
            8'h05: begin mReq = 1; mOut = {48'd0, rd}; end
            8'h06: mOut = {32'd0, ts};
            8'h07, 8'h10: mOut = {48'd0, tg};
            8'h09: begin mRst = 1; mErr = 1'b0; modelCfgClear(); end
            default: mErr = 1'b1;
        endcase
    endtask

    task automatic checkModel(input int n);
        chk($sformatf("rnd%0d_err", n), 64'(hubIf.status[2]), 64'(mErr));
        chk($sformatf("rnd%0d_buf", n), {preTriggerCount, totalSampleCount}, {mPre, mTot});
        chk($sformatf("rnd%0d_trig", n), trigAll, {mPat, mAct, mDc, mChan, 5'd0, mMode});
        chk($sformatf("rnd%0d_regOut", n), regOutAll, mOut);
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [63:0] args;
        logic        run;
        logic        expErr;
        int          expStart;
        logic [31:0] expPre;
        logic [31:0] expTotal;
        logic [63:0] expOut;
    } vec_t;

    vec_t vecs [17];
    logic [7:0] cmdPool [16];

    initial begin
        int s0, a0, r0, q0;

        vecs[0]  = '{8'h04, {32'd20, 32'd110},  1'b0, 1'b0, 0, 32'd20, 32'd110, 64'd0};
        vecs[1]  = '{8'h04, {32'd200, 32'd100}, 1'b0, 1'b1, 0, 32'd20, 32'd110, 64'd0};
        vecs[2]  = '{8'h09, 64'd0,              1'b0, 1'b0, 0, 32'd0,  32'd0,   64'd0};
        vecs[3]  = '{8'h01, 64'd0,              1'b0, 1'b0, 1, 32'd0,  32'd0,   64'd0};
        vecs[4]  = '{8'h01, 64'd0,              1'b1, 1'b1, 0, 32'd0,  32'd0,   64'd0};
        vecs[5]  = '{8'h09, 64'd0,              1'b0, 1'b0, 0, 32'd0,  32'd0,   64'd0};
        vecs[6]  = '{8'h06, 64'd0,              1'b0, 1'b0, 0, 32'd0,  32'd0,   64'h0012_3456};
        vecs[7]  = '{8'h07, 64'd0,              1'b0, 1'b0, 0, 32'd0,  32'd0,   64'h0000_BEEF};
        vecs[8]  = '{8'h10, 64'd0,              1'b0, 1'b0, 0, 32'd0,  32'd0,   64'h0000_BEEF};
        vecs[9]  = '{8'h0B, 64'd0,              1'b0, 1'b1, 0, 32'd0,  32'd0,   64'h0000_BEEF};
        vecs[10] = '{8'h09, 64'd0,              1'b0, 1'b0, 0, 32'd0,  32'd0,   64'h0000_BEEF};
        vecs[11] = '{8'h04, 64'd0,              1'b0, 1'b1, 0, 32'd0,  32'd0,   64'h0000_BEEF};
        vecs[12] = '{8'h09, 64'd0,              1'b0, 1'b0, 0, 32'd0,  32'd0,   64'h0000_BEEF};
        vecs[13] = '{8'h04, {32'd1, 32'd2},     1'b1, 1'b1, 0, 32'd0,  32'd0,   64'h0000_BEEF};
        vecs[14] = '{8'h09, 64'd0,              1'b0, 1'b0, 0, 32'd0,  32'd0,   64'h0000_BEEF};
        vecs[15] = '{8'h04, {32'd50, 32'd50},   1'b0, 1'b0, 0, 32'd50, 32'd50,  64'h0000_BEEF};
        vecs[16] = '{8'h00, 64'd0,              1'b0, 1'b0, 0, 32'd50, 32'd50,  64'h0000_BEEF};

        cmdPool = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                    8'h09, 8'h10, 8'h0C, 8'hFF, 8'h03, 8'h04, 8'h05, 8'h03};

        resetn = 1'b0;
        hubIf.command = 8'h00; hubIf.commandStrobe = 1'b0;
        hubIf.regIn0 = 0; hubIf.regIn1 = 0; hubIf.regIn2 = 0; hubIf.regIn3 = 0;
        hubIf.regIn4 = 0; hubIf.regIn5 = 0; hubIf.regIn6 = 0; hubIf.regIn7 = 0;
        captureRunning = 1'b0; captureDone = 1'b0;
        traceSize = 32'h0012_3456; triggerSample = 16'hBEEF;
        bufRdValid = 1'b0; bufRdData = 16'h0000;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_status", 64'(hubIf.status), 64'd0);
        chk("rst_regOut", regOutAll, 64'd0);
        chk("rst_trig", trigAll, 64'h0000_FFFF_0000_0000);
        chk("rst_buf", {preTriggerCount, totalSampleCount}, 64'd0);
        chk("rst_pulses", 64'({startPulse, abortPulse, captureResetPulse, bufRdReq}), 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Directed vector table.
        for (int i = 0; i < 17; i++) begin
            captureRunning = vecs[i].run;
            s0 = startCnt;
            runCmd(vecs[i].cmd, vecs[i].args, 0, 16'h0000);
            chk($sformatf("vec%0d_err", i), 64'(hubIf.status[2]), 64'(vecs[i].expErr));
            chk($sformatf("vec%0d_start", i), 64'(startCnt - s0), 64'(vecs[i].expStart));
            chk($sformatf("vec%0d_buf", i), {preTriggerCount, totalSampleCount},
                {vecs[i].expPre, vecs[i].expTotal});
            chk($sformatf("vec%0d_regOut", i), regOutAll, vecs[i].expOut);
        end
        captureRunning = 1'b0;

        // Trigger configuration, including the channel-16 edge boundary.
        runCmd(8'h03, {8'h06, 8'h02, 16'h00F0, 16'hFFFF, 16'h1234}, 0, 16'h0);
        chk("trig_ok", trigAll, 64'h1234_FFFF_00F0_0206);
        chk("trig_ok_err", 64'(hubIf.status[2]), 64'd0);
        runCmd(8'h03, {8'h02, 8'd16, 16'h0000, 16'h0000, 16'h5555}, 0, 16'h0);
        chk("trig_ch16_kept", trigAll, 64'h1234_FFFF_00F0_0206);
        chk("trig_ch16_err", 64'(hubIf.status[2]), 64'd1);
        runCmd(8'h09, 64'd0, 0, 16'h0);
        chk("reset_trig", trigAll, 64'h0000_FFFF_0000_0000);
        chk("reset_err", 64'(hubIf.status[2]), 64'd0);
        runCmd(8'h03, {8'h01, 8'd20, 16'hAAAA, 16'h00FF, 16'h5555}, 0, 16'h0);
        chk("trig_ch20_noedge", trigAll, 64'h5555_00FF_AAAA_1401);
        runCmd(8'h03, {8'h02, 8'h0F, 16'h0F0F, 16'h1111, 16'h7777}, 0, 16'h0);
        chk("trig_ch15_edge", trigAll, 64'h7777_1111_0F0F_0F02);
        chk("trig_ch15_err", 64'(hubIf.status[2]), 64'd0);

        // Trace-data read answered five clocks after the request.
        q0 = reqCnt; s0 = startCnt;
        pulseStrobe(8'h05, 64'd0);
        chk("rd_req_high", 64'(bufRdReq), 64'd1);
        @(negedge clk);
        chk("rd_req_single", 64'(bufRdReq), 64'd0);
        chk("rd_wait_busy", 64'({hubIf.status[3], hubIf.status[0]}), 64'b01);
        pulseStrobe(8'h01, 64'd0);  // ignored while waiting for the sample
        repeat (3) @(negedge clk);
        chk("rd_wait_noack", 64'(hubIf.status[3]), 64'd0);
        bufRdData = 16'hA55A; bufRdValid = 1'b1;
        @(negedge clk);
        bufRdValid = 1'b0;
        chk("rd_ack", 64'(hubIf.status[3]), 64'd1);
        chk("rd_data", regOutAll, 64'h0000_A55A);
        chk("rd_ignored_strobe", 64'({startCnt - s0, 1'(hubIf.status[2])}), 64'd0);
        chk("rd_req_count", 64'(reqCnt - q0), 64'd1);
        pulseStrobe(8'h08, 64'd0);
        chk("rd_done", 64'(hubIf.status), 64'd0);

        // Non-ACK strobe during ACK_WAIT is ignored but flags an error.
        s0 = startCnt;
        pulseStrobe(8'h00, 64'd0);
        @(negedge clk);
        chk("ackwait_ack", 64'(hubIf.status[3]), 64'd1);
        pulseStrobe(8'h01, 64'd0);
        chk("ackwait_stray", 64'({hubIf.status[3], hubIf.status[2]}), 64'b11);
        chk("ackwait_nostart", 64'(startCnt - s0), 64'd0);
        pulseStrobe(8'h08, 64'd0);
        chk("ackwait_done", 64'({hubIf.status[3], hubIf.status[0]}), 64'd0);
        runCmd(8'h09, 64'd0, 0, 16'h0);
        chk("ackwait_cleared", 64'(hubIf.status[2]), 64'd0);

        // ACK in IDLE is dropped silently.
        pulseStrobe(8'h08, 64'd0);
        @(negedge clk);
        chk("idle_ack", 64'(hubIf.status), 64'd0);

        // Running/done mirror with one clock of delay.
        captureRunning = 1'b1; captureDone = 1'b1;
        #1;
        chk("mirror_delay", 64'({hubIf.status[4], hubIf.status[1]}), 64'd0);
        @(negedge clk);
        chk("mirror_set", 64'(hubIf.status), 64'h12);
        captureRunning = 1'b0; captureDone = 1'b0;
        @(negedge clk);
        chk("mirror_clr", 64'(hubIf.status), 64'h00);

        // Trace-data read with no sample ever arriving.
        begin
            int lat;
            pulseStrobe(8'h05, 64'd0);
            lat = 1;
`ifdef CAPTURE_CMD_DECODER_TIMEOUT_EN
            while (!hubIf.status[3] && lat < TimeoutClks + 200) begin
                @(negedge clk);
                lat++;
            end
            chk("timeout_latency", 64'(lat), 64'(TimeoutClks + 2));
            chk("timeout_data", regOutAll, 64'h0000_DEAD);
            chk("timeout_err", 64'(hubIf.status[2]), 64'd1);
            pulseStrobe(8'h08, 64'd0);
            runCmd(8'h09, 64'd0, 0, 16'h0);
`else
            repeat (TimeoutClks + 76) @(negedge clk);
            chk("nowait_limit", 64'({hubIf.status[3], hubIf.status[0]}), 64'b01);
            bufRdData = 16'h1234; bufRdValid = 1'b1;
            @(negedge clk);
            bufRdValid = 1'b0;
            chk("late_ack", 64'(hubIf.status[3]), 64'd1);
            chk("late_data", regOutAll, 64'h0000_1234);
            pulseStrobe(8'h08, 64'd0);
`endif
        end

        // Asynchronous reset while waiting for a sample.
        pulseStrobe(8'h05, 64'd0);
        @(negedge clk);
        chk("arst_pre", 64'(hubIf.status), 64'h01);
        #2 resetn = 1'b0;
        #1;
        chk("arst_status", 64'(hubIf.status), 64'd0);
        chk("arst_pulses", 64'({startPulse, abortPulse, captureResetPulse, bufRdReq}), 64'd0);
        chk("arst_regOut", regOutAll, 64'd0);
        chk("arst_trig", trigAll, 64'h0000_FFFF_0000_0000);
        @(negedge clk);
        resetn = 1'b1;
        modelReset();
        @(negedge clk);
        runCmd(8'h00, 64'd0, 0, 16'h0);

        // Randomized commands against the model.
        for (int n = 0; n < 80; n++) begin
            logic [7:0]  c;
            logic [63:0] a;
            logic        run;
            int          d;
            logic [15:0] rd;
            int unsigned tot, pre;
            c = cmdPool[$urandom_range(0, 15)];
            a = {$urandom, $urandom};
            if (c == 8'h04 && $urandom_range(0, 1) == 1) begin
                tot = $urandom_range(1, 1000);
                pre = $urandom_range(0, tot);
                a   = {pre, tot};
            end
            if (c == 8'h03) a[55:48] = 8'($urandom_range(0, 24));
            run = ($urandom_range(0, 3) == 0);
            d   = $urandom_range(0, 4);
            rd  = 16'($urandom);
            captureRunning = run;
            traceSize      = $urandom;
            triggerSample  = 16'($urandom);
            s0 = startCnt; a0 = abortCnt; r0 = rstCnt; q0 = reqCnt;
            runCmd(c, a, d, rd);
            modelCmd(c, a, run, traceSize, triggerSample, rd);
            checkModel(n);
            chk($sformatf("rnd%0d_pulses", n),
                {16'(startCnt - s0), 16'(abortCnt - a0), 16'(rstCnt - r0), 16'(reqCnt - q0)},
                {16'(mStart), 16'(mAbort), 16'(mRst), 16'(mReq)});
        end
        captureRunning = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/capture_cmd_decoder.md
Name: capture_cmd_decoder

Overview:
Command front end inside LogicCaptureTop; sits directly downstream of the hub command interface. Samples command/commandStrobe and regIn0..7, decodes function codes, loads buffer/trigger configuration registers, pulses control strobes to the capture core, and returns read data on regOut0..7. Drives status[3] (ack) and completes each command through a two-phase ack handshake with the hub.

Parameters:
SAMPLE_W, 16, width of one trace sample / trigger sample
TIMEOUT_CLKS, 1024, max clocks to wait for bufRdValid on a trace-data read (used only with the optional feature)

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
command  input  8  function code from hub
commandStrobe  input  1  one-clock command-valid pulse
regIn0..regIn7  input  8 each  argument registers from hub
regOut0..regOut7  output  8 each  result registers to hub
status  output  8  [0]busy [1]running [2]error(sticky) [3]ack [4]captureDone [7:5]=0
preTriggerCount  output  32  buffer config
totalSampleCount  output  32  buffer config
desiredPattern, activeChannels, dontCare  output  16 each  pattern trigger config
edgeTriggerChannel  output  8  edge trigger channel
edgeTriggerType, edgeTriggerEnable, patternTriggerEnable  output  1 each  trigger mode bits
startPulse, abortPulse, captureResetPulse  output  1 each  one-clock control strobes to capture core
captureRunning, captureDone  input  1 each  capture core state
traceSize  input  32  samples stored
triggerSample  input  SAMPLE_W  sample at trigger
bufRdReq  output  1  one-clock request for next trace sample
bufRdValid  input  1  trace sample valid
bufRdData  input  SAMPLE_W  trace sample

Behaviour:
- Reset (async, resetn=0): FSM=IDLE; all outputs 0 except activeChannels=16'hFFFF; error cleared.
- Codes: 00 NOP, 01 START, 02 ABORT, 03 TRIG_CFG, 04 BUF_CFG, 05 READ_TRACE_DATA, 06 READ_TRACE_SIZE, 07 and 10 READ_TRIGGER_SAMPLE (aliases), 08 ACK, 09 RESET. Any other code: error=1, then normal ack.
- FSM: IDLE -> EXEC on commandStrobe with command!=ACK; command and regIn0..7 captured the same edge. EXEC (1 clk) performs action -> ACK_WAIT, except READ_TRACE_DATA -> RD_WAIT. RD_WAIT -> ACK_WAIT on bufRdValid. ACK_WAIT -> IDLE on commandStrobe with command=08.
- status[3]=1 exactly while in ACK_WAIT; status[0]=1 whenever FSM!=IDLE; status[1]/[4] mirror captureRunning/captureDone registered (1-clk delay).
- Strobe-to-ack latency: 2 clocks for all commands except READ_TRACE_DATA (2 + bufRdValid wait).
- BUF_CFG: preTriggerCount={regIn7..regIn4}, totalSampleCount={regIn3..regIn0}. If pre>total or total==0: registers unchanged, error=1.
- TRIG_CFG: desiredPattern={regIn1,regIn0}, activeChannels={regIn3,regIn2}, dontCare={regIn5,regIn4}, edgeTriggerChannel=regIn6, {edgeTriggerType,edgeTriggerEnable,patternTriggerEnable}=regIn7[2:0]. Channel>=16 with edge enable: unchanged, error=1.
- Config writes while captureRunning=1: rejected, error=1.
- START: startPulse for 1 clk in EXEC; if captureRunning=1, no pulse, error=1. ABORT: abortPulse unconditionally.
- RESET: captureResetPulse 1 clk; config registers return to reset values; error cleared.
- READ_TRACE_SIZE: {regOut3..regOut0}=traceSize, regOut7..4=0. READ_TRIGGER_SAMPLE: {regOut1,regOut0}=triggerSample, others 0.
- READ_TRACE_DATA: bufRdReq 1 clk in EXEC; bufRdData latched into {regOut1,regOut0} on bufRdValid (valid same cycle as req accepted).
- regOut hold last result until next read command or reset.
- Strobes in EXEC/RD_WAIT ignored; non-ACK strobe in ACK_WAIT ignored and sets error. ACK strobe in IDLE ignored silently.
- Error is sticky; cleared only by reset or RESET command.

Optional Feature:
CAPTURE_CMD_DECODER_TIMEOUT_EN: defined -> RD_WAIT counts clocks; after TIMEOUT_CLKS without bufRdValid goes to ACK_WAIT with regOut0..1=16'hDEAD and error=1. Undefined -> RD_WAIT waits indefinitely, no counter logic.

Test Plan:
- BUF_CFG with regIn={pre=20,total=110} -> ack at strobe+2, preTriggerCount=20, totalSampleCount=110, error=0; ACK strobe -> status=0.
- TRIG_CFG regIn6=2, regIn7=3'b110, activeChannels=FFFF -> edgeTriggerChannel=2, type=1, edge enable=1, pattern enable=0.
- BUF_CFG pre=200,total=100 -> config unchanged, error=1, ack still given; RESET command -> error=0, activeChannels=FFFF.
- START with captureRunning=0 -> single startPulse; START with captureRunning=1 -> no pulse, error=1.
- READ_TRACE_DATA, bufRdValid after 5 clks with 16'hA55A -> regOut0=5A, regOut1=A5, ack after valid; with macro and no valid -> regOut=DEAD after 1024 clks, error=1.
- Async resetn low during RD_WAIT -> immediate IDLE, status=0, all pulses 0.
